// File: rtl/sync_strobe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_strobe
// Description : Turns a level pending request into a half-cycle strobe
//               followed by a done acknowledge (four-phase handshake).
// Revision    : 1.0 - initial release
// ============================================================================
module sync_strobe #(
    parameter int PENDING_SYNC_STAGES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic pending,
    output logic strobe,
    output logic done
);

    // State is the pair {r_req, r_ack}; each transition flips exactly one bit.
    localparam logic [1:0] c_ST_IDLE    = 2'b00;
    localparam logic [1:0] c_ST_STROBE  = 2'b10;
    localparam logic [1:0] c_ST_DONE    = 2'b11;
    localparam logic [1:0] c_ST_ACK_CLR = 2'b01;

    logic       w_pend;
    logic       r_req;
    logic       r_ack;
    logic [1:0] w_state;
    logic       w_req_next;
    logic       w_ack_next;

    generate
        if (PENDING_SYNC_STAGES == 0) begin : g_no_sync
            assign w_pend = pending;
        end else begin : g_sync
            logic [PENDING_SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= pending;
                    for (int i = 1; i < PENDING_SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_pend = r_sync[PENDING_SYNC_STAGES-1];
        end
    endgenerate

    assign w_state = {r_req, r_ack};

    // r_req is only evaluated at posedges and r_ack only at negedges.
    always_comb begin
        w_req_next = 1'b0;
        w_ack_next = 1'b0;
        case (w_state)
            c_ST_IDLE: begin
                w_req_next = w_pend;
                w_ack_next = 1'b0;
            end
            c_ST_STROBE: begin
                w_req_next = 1'b1;
                w_ack_next = 1'b1;
            end
            c_ST_DONE: begin
                w_req_next = w_pend;
                w_ack_next = 1'b1;
            end
            c_ST_ACK_CLR: begin
                w_req_next = w_pend;
                w_ack_next = 1'b0;
            end
            default: begin
                w_req_next = 1'b0;
                w_ack_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req <= 1'b0;
        end else begin
            r_req <= w_req_next;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_ack_next;
        end
    end

    always_comb begin
        strobe = (w_state == c_ST_STROBE);
        done   = (w_state == c_ST_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_strobe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sync_strobe
// Description : Scoreboard bench for sync_strobe with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_strobe;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic pending = 1'b0;
    logic strobe;
    logic done;

    sync_strobe #(
        .PENDING_SYNC_STAGES(0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pending(pending),
        .strobe (strobe),
        .done   (done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         is_count;
        logic [1:0] exp_out;
        int         exp_cnt;
    } exp_t;

    exp_t exp_q[$];
    event ev_push;
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   strobe_rises = 0;
    int   base_cnt     = 0;

    task automatic expect_out(input string name, input logic [1:0] e);
        exp_t it;
        it.name     = name;
        it.is_count = 1'b0;
        it.exp_out  = e;
        it.exp_cnt  = 0;
        exp_q.push_back(it);
        ->ev_push;
    endtask

    task automatic expect_count(input string name, input int e);
        exp_t it;
        it.name     = name;
        it.is_count = 1'b1;
        it.exp_out  = 2'b00;
        it.exp_cnt  = e;
        exp_q.push_back(it);
        ->ev_push;
    endtask

    task automatic at_pos;
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg;
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: drains expectations against the live outputs
    initial begin
        exp_t it;
        forever begin
            @(ev_push);
            while (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                n_checks++;
                if (it.is_count) begin
                    if (strobe_rises != it.exp_cnt) begin
                        n_errors++;
                        $display("FAIL %s: strobe count got %0d expected %0d at %0t",
                                 it.name, strobe_rises, it.exp_cnt, $time);
                    end
                end else if ({strobe, done} !== it.exp_out) begin
                    n_errors++;
                    $display("FAIL %s: {strobe,done} got %b expected %b at %0t",
                             it.name, {strobe, done}, it.exp_out, $time);
                end
            end
        end
    end

    initial forever begin
        @(posedge strobe);
        strobe_rises++;
    end

    initial begin
        time t_rise;
        forever begin
            @(posedge strobe);
            t_rise = $time;
            @(negedge strobe);
            if (!reset) begin
                n_checks++;
                if (($time - t_rise) != 5) begin
                    n_errors++;
                    $display("FAIL strobe_width: got %0t expected 5 at %0t",
                             $time - t_rise, $time);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk or negedge clk);
        #1;
        n_checks++;
        if (strobe && done) begin
            n_errors++;
            $display("FAIL overlap: strobe=%b done=%b expected not both 1 at %0t",
                     strobe, done, $time);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        expect_out("powerup", 2'b00);

        // Basic request with held pending
        at_pos;
        base_cnt = strobe_rises;
        pending  = 1'b1;
        expect_out("no_comb_path", 2'b00);
        at_pos;
        expect_out("strobe_high", 2'b10);
        at_neg;
        expect_out("done_high", 2'b01);
        for (int i = 0; i < 3; i++) begin
            at_pos;
            expect_out("done_hold_pos", 2'b01);
            at_neg;
            expect_out("done_hold_neg", 2'b01);
        end
        pending = 1'b0;
        at_pos;
        expect_out("done_clear", 2'b00);
        expect_count("one_strobe_held", base_cnt + 1);
        at_neg;
        expect_out("idle_neg", 2'b00);

        // Reset during strobe, then fresh request after release
        base_cnt = strobe_rises;
        pending  = 1'b1;
        at_pos;
        expect_out("strobe_before_reset", 2'b10);
        #2;
        reset = 1'b1;
        #1;
        expect_out("reset_async", 2'b00);
        at_neg;
        expect_out("reset_held_neg", 2'b00);
        at_pos;
        expect_out("reset_held_pos", 2'b00);
        reset = 1'b0;
        at_pos;
        expect_out("post_reset_strobe", 2'b10);
        at_neg;
        expect_out("post_reset_done", 2'b01);
        pending = 1'b0;
        at_pos;
        expect_out("post_reset_idle", 2'b00);
        expect_count("reset_strobes", base_cnt + 2);

        // One-cycle pulse: pending dropped during the strobe
        base_cnt = strobe_rises;
        pending  = 1'b1;
        at_pos;
        expect_out("pulse_strobe", 2'b10);
        pending = 1'b0;
        at_neg;
        expect_out("pulse_done", 2'b01);
        at_pos;
        expect_out("pulse_idle", 2'b00);
        at_pos;
        expect_out("pulse_idle2", 2'b00);
        expect_count("pulse_strobes", base_cnt + 1);

        // Back-to-back requests with a one-cycle gap
        base_cnt = strobe_rises;
        pending  = 1'b1;
        at_pos;
        expect_out("b2b_strobe1", 2'b10);
        at_neg;
        expect_out("b2b_done1", 2'b01);
        pending = 1'b0;
        at_pos;
        expect_out("b2b_gap", 2'b00);
        pending = 1'b1;
        at_pos;
        expect_out("b2b_strobe2", 2'b10);
        at_neg;
        expect_out("b2b_done2", 2'b01);
        pending = 1'b0;
        at_pos;
        expect_out("b2b_idle", 2'b00);
        expect_count("b2b_strobes", base_cnt + 2);

        // Pending glitch between sampling edges is not seen
        base_cnt = strobe_rises;
        pending  = 1'b1;
        #2;
        pending = 1'b0;
        at_pos;
        expect_out("glitch_ignored", 2'b00);
        expect_count("glitch_strobes", base_cnt);

        #1;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() > 0) #1;
        end
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
